// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids, load masks.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Optional feature macro used by importers: ARB_ROUND_ROBIN_EN.
package ysyx_22041211_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    // Owner / grant identity of a transaction.
    localparam logic ARB_OWN_IFU = 1'b0;
    localparam logic ARB_OWN_LSU = 1'b1;

    // Byte masks shared with the rest of the core.
    localparam logic [7:0] LOAD_MASK_8  = 8'h01;
    localparam logic [7:0] LOAD_MASK_16 = 8'h03;
    localparam logic [7:0] LOAD_MASK_32 = 8'h0F;
    localparam logic [7:0] LOAD_MASK_64 = 8'hFF;

endpackage

// File: rtl/ysyx_22041211_arb_pick.sv
// Combinational 2-way picker between IFU and LSU requests; grant is one-hot {lsu, ifu}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; grant is zero when neither requester is valid.
// ARB_ROUND_ROBIN_EN defined: ties go to the requester not granted last.
// Undefined: fixed priority, LSU wins ties; last_grant is ignored.
// Ports: ifu_valid/lsu_valid request flags, last_grant previous winner, grant {lsu, ifu}.
module ysyx_22041211_arb_pick
    import ysyx_22041211_mem_arbiter_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = 2'b00;
        if (ifu_valid && lsu_valid) begin
            grant = (last_grant == ARB_OWN_LSU) ? 2'b01 : 2'b10;
        end else if (ifu_valid) begin
            grant = 2'b01;
        end else if (lsu_valid) begin
            grant = 2'b10;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // LSU first so outstanding memory ops drain before the next fetch.
    always_comb begin
        grant = 2'b00;
        if (lsu_valid) begin
            grant = 2'b10;
        end else if (ifu_valid) begin
            grant = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one transaction in flight.
// Latency: accept at N, mem_req_valid at N+1, response passed through at N+2 with zero-wait memory.
// Backpressure: requesters are only ready in IDLE; REQ holds fields until mem_req_ready.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie break (else LSU wins ties).
// Ports: ifu_* fetch request/response, lsu_* load/store request/response,
//        mem_* registered request to memory and its response; clk/rst synchronous active-high.
module ysyx_22041211_mem_arbiter
    import ysyx_22041211_mem_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int MASK_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [DATA_LEN-1:0] ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [DATA_LEN-1:0] lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [MASK_LEN-1:0] lsu_mask,
    output logic                lsu_rsp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [DATA_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [MASK_LEN-1:0] mem_mask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    arb_state_e          state_q, state_d;
    logic                owner_q, owner_d;
    logic [DATA_LEN-1:0] addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [MASK_LEN-1:0] mask_q, mask_d;
    logic [1:0]          grant;
    logic                last_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = ARB_OWN_LSU;
`endif

    ysyx_22041211_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        ifu_rdata     = '0;
        lsu_rdata     = '0;
        mem_req_valid = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant[0]) begin
                    // Fetches are always full-word reads.
                    ifu_req_ready = 1'b1;
                    owner_d       = ARB_OWN_IFU;
                    addr_d        = ifu_addr;
                    wen_d         = 1'b0;
                    wdata_d       = '0;
                    mask_d        = MASK_LEN'(LOAD_MASK_32);
                    state_d       = ARB_REQ;
                end else if (grant[1]) begin
                    lsu_req_ready = 1'b1;
                    owner_d       = ARB_OWN_LSU;
                    addr_d        = lsu_addr;
                    wen_d         = lsu_wen;
                    wdata_d       = lsu_wdata;
                    mask_d        = lsu_mask;
                    state_d       = ARB_REQ;
                end
`ifdef ARB_ROUND_ROBIN_EN
                if (grant != 2'b00) begin
                    last_grant_d = grant[1] ? ARB_OWN_LSU : ARB_OWN_IFU;
                end
`endif
            end
            ARB_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // Response is passed straight through to the owner in the same cycle.
                if (mem_rsp_valid) begin
                    if (owner_q == ARB_OWN_IFU) begin
                        ifu_rsp_valid = 1'b1;
                        ifu_rdata     = mem_rdata;
                    end else begin
                        lsu_rsp_valid = 1'b1;
                        lsu_rdata     = wen_q ? '0 : mem_rdata;
                    end
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // While reset is held nothing is accepted, launched or answered.
        if (rst) begin
            ifu_req_ready = 1'b0;
            lsu_req_ready = 1'b0;
            ifu_rsp_valid = 1'b0;
            lsu_rsp_valid = 1'b0;
            ifu_rdata     = '0;
            lsu_rdata     = '0;
            mem_req_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= ARB_OWN_LSU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            mask_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= ARB_OWN_LSU;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_mask  = mask_q;

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed, table-driven bench for the IFU/LSU memory arbiter.
// Latency: drives at posedge+1, samples at negedge.
// Backpressure: memory ready/response timing is scripted per sequence.
module tb_ysyx_22041211_mem_arbiter;
    import ysyx_22041211_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_mask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_mask;

    always #5 clk = ~clk;

    ysyx_22041211_mem_arbiter #(.DATA_LEN(32), .MASK_LEN(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] lsu_wdata;
        logic [7:0]  lsu_mask;
        logic [31:0] mem_rdata;
        logic        exp_own;
        logic [31:0] exp_addr;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_mask;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
    endtask

    // Full transaction: accept (IDLE), launch (REQ), zero-wait response (WAIT), back to IDLE.
    task automatic run_txn(input vec_t v, input string nm);
        ifu_req_valid = v.ifu_v;
        lsu_req_valid = v.lsu_v;
        ifu_addr      = v.ifu_addr;
        lsu_addr      = v.lsu_addr;
        lsu_wen       = v.lsu_wen;
        lsu_wdata     = v.lsu_wdata;
        lsu_mask      = v.lsu_mask;
        @(negedge clk);
        chk1({nm, "_ifu_ready"}, ifu_req_ready, v.exp_own == ARB_OWN_IFU);
        chk1({nm, "_lsu_ready"}, lsu_req_ready, v.exp_own == ARB_OWN_LSU);
        chk1({nm, "_idle_memreq"}, mem_req_valid, 1'b0);
        step();
        // Both requesters assert new garbage; latched fields must not move.
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr      = 32'hFFFF_FFF0;
        lsu_addr      = 32'h0BAD_0000;
        lsu_wen       = ~v.lsu_wen;
        lsu_wdata     = ~v.lsu_wdata;
        lsu_mask      = ~v.lsu_mask;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk1({nm, "_memreq"}, mem_req_valid, 1'b1);
        chk({nm, "_addr"}, mem_addr, v.exp_addr);
        chk1({nm, "_wen"}, mem_wen, v.exp_wen);
        chk({nm, "_wdata"}, mem_wdata, v.exp_wdata);
        chk({nm, "_mask"}, {24'h0, mem_mask}, {24'h0, v.exp_mask});
        chk1({nm, "_req_ready_busy"}, ifu_req_ready | lsu_req_ready, 1'b0);
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.mem_rdata;
        @(negedge clk);
        chk1({nm, "_ifu_rsp"}, ifu_rsp_valid, v.exp_own == ARB_OWN_IFU);
        chk1({nm, "_lsu_rsp"}, lsu_rsp_valid, v.exp_own == ARB_OWN_LSU);
        chk({nm, "_rdata"}, (v.exp_own == ARB_OWN_IFU) ? ifu_rdata : lsu_rdata, v.exp_rdata);
        chk1({nm, "_wait_memreq"}, mem_req_valid, 1'b0);
        step();
        idle_inputs();
        @(negedge clk);
        chk({nm, "_post_rsp"}, {30'h0, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
        step();
    endtask

    initial begin
        // IFU only fetch.
        vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 8'h0, 32'h0000_0413,
                    ARB_OWN_IFU, 32'h8000_0000, 1'b0, 32'h0, LOAD_MASK_32, 32'h0000_0413};
        // LSU byte store: rdata must come back 0.
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, LOAD_MASK_8, 32'h1234_5678,
                    ARB_OWN_LSU, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, LOAD_MASK_8, 32'h0};
        // Last grant is LSU here, so vectors 2..4 exercise the tie policy.
`ifdef ARB_ROUND_ROBIN_EN
        vecs[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_2000, 1'b0, 32'h1111_1111, LOAD_MASK_16, 32'hCAFE_F00D,
                    ARB_OWN_IFU, 32'h8000_0004, 1'b0, 32'h0, LOAD_MASK_32, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h8000_2000, 1'b0, 32'h1111_1111, LOAD_MASK_16, 32'h00C5_8593,
                    ARB_OWN_LSU, 32'h8000_2000, 1'b0, 32'h1111_1111, LOAD_MASK_16, 32'h00C5_8593};
        vecs[4] = '{1'b1, 1'b1, 32'h8000_0008, 32'h8000_3000, 1'b1, 32'hA5A5_A5A5, LOAD_MASK_64, 32'h55AA_55AA,
                    ARB_OWN_IFU, 32'h8000_0008, 1'b0, 32'h0, LOAD_MASK_32, 32'h55AA_55AA};
`else
        vecs[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_2000, 1'b0, 32'h1111_1111, LOAD_MASK_16, 32'hCAFE_F00D,
                    ARB_OWN_LSU, 32'h8000_2000, 1'b0, 32'h1111_1111, LOAD_MASK_16, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h0, 8'h0, 32'h00C5_8593,
                    ARB_OWN_IFU, 32'h8000_0004, 1'b0, 32'h0, LOAD_MASK_32, 32'h00C5_8593};
        vecs[4] = '{1'b1, 1'b1, 32'h8000_0008, 32'h8000_3000, 1'b1, 32'hA5A5_A5A5, LOAD_MASK_64, 32'h55AA_55AA,
                    ARB_OWN_LSU, 32'h8000_3000, 1'b1, 32'hA5A5_A5A5, LOAD_MASK_64, 32'h0};
`endif
        // LSU word load.
        vecs[5] = '{1'b0, 1'b1, 32'h0, 32'h8000_0010, 1'b0, 32'h0, LOAD_MASK_32, 32'h0BAD_C0DE,
                    ARB_OWN_LSU, 32'h8000_0010, 1'b0, 32'h0, LOAD_MASK_32, 32'h0BAD_C0DE};

        // Reset: requests are ignored while reset is held.
        rst       = 1'b1;
        idle_inputs();
        ifu_addr  = 32'h0;
        lsu_addr  = 32'h0;
        lsu_wen   = 1'b0;
        lsu_wdata = 32'h0;
        lsu_mask  = 8'h0;
        step();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        @(negedge clk);
        chk1("rst_ready", ifu_req_ready | lsu_req_ready, 1'b0);
        step();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_memreq", mem_req_valid, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_mask_wen", {23'h0, mem_wen, mem_mask}, 32'h0);
        chk("rst_rsp", {30'h0, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
        step();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Stall: memory withholds ready for 5 cycles then the response for 3.
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_4000;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0000_0077;
        lsu_mask      = LOAD_MASK_16;
        @(negedge clk);
        chk1("stall_accept", lsu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        lsu_addr      = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("stall_req_valid", mem_req_valid, 1'b1);
            chk("stall_req_addr", mem_addr, 32'h8000_4000);
            chk("stall_req_wdata", mem_wdata, 32'h0000_0077);
            chk("stall_req_mask_wen", {23'h0, mem_wen, mem_mask}, {24'h0, LOAD_MASK_16});
            chk1("stall_req_ready", ifu_req_ready | lsu_req_ready, 1'b0);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("stall_wait_rsp", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
            chk1("stall_wait_memreq", mem_req_valid, 1'b0);
            chk("stall_wait_addr", mem_addr, 32'h8000_4000);
            chk1("stall_wait_ready", ifu_req_ready | lsu_req_ready, 1'b0);
            step();
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0F0F_0F0F;
        @(negedge clk);
        chk1("stall_lsu_rsp", lsu_rsp_valid, 1'b1);
        chk1("stall_ifu_rsp", ifu_rsp_valid, 1'b0);
        chk("stall_rdata", lsu_rdata, 32'h0F0F_0F0F);
        step();
        idle_inputs();
        step();

        // Reset while waiting: the late response must be dropped.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_5000;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        chk1("midrst_rsp", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
        step();
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hBADB_AD00;
        @(negedge clk);
        chk1("late_rsp_ifu", ifu_rsp_valid, 1'b0);
        chk1("late_rsp_lsu", lsu_rsp_valid, 1'b0);
        chk1("late_rsp_memreq", mem_req_valid, 1'b0);
        chk("late_rsp_addr", mem_addr, 32'h0);
        step();
        idle_inputs();
        run_txn('{1'b1, 1'b0, 32'h8000_5000, 32'h0, 1'b0, 32'h0, 8'h0, 32'h0010_0073,
                  ARB_OWN_IFU, 32'h8000_5000, 1'b0, 32'h0, LOAD_MASK_32, 32'h0010_0073}, "after_rst");

        // Spurious response in IDLE.
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1357_9BDF;
        @(negedge clk);
        chk1("spur_rsp", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
        step();
        idle_inputs();
        @(negedge clk);
        chk1("spur_memreq", mem_req_valid, 1'b0);
        step();
        run_txn(vecs[5], "after_spur");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
